divider: RTL and testbench
==========================

Name: divider

Overview:
- Iterative restoring divider for the execute stage. It is the inverse-operation counterpart of the shift-add multiplier and uses the same valid/data_ok handshake.
- It produces a quotient and a remainder for signed or unsigned 64-bit operands, one quotient bit per cycle.
- Results follow RISC-V DIV/DIVU/REM/REMU semantics, so the execute stage selects the quotient or the remainder directly.

Parameters:
- WIDTH, 64, operand and result width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous reset, active-low.
- valid  input  1  request; held high by execute until data_ok is seen.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled at accept.
- srca  input  WIDTH  dividend; sampled at accept.
- srcb  input  WIDTH  divisor; sampled at accept.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- data_ok  output  1  one-cycle pulse; quotient and remainder are valid in this cycle.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, counter = 0.
  - quotient = 0, remainder = 0, data_ok = 0.
  - Reset mid-operation discards all work; no data_ok follows.
- States:
  - IDLE:
    - On a clk edge with valid = 1, latch the operand magnitudes: |srca| and |srcb| when is_signed, else raw.
    - Latch neg_q = is_signed & (srca[MSB] ^ srcb[MSB]) & (srcb != 0).
    - Latch neg_r = is_signed & srca[MSB].
    - Clear the partial remainder, set counter = 0, go to BUSY.
  - BUSY, each edge:
    - Shift {partial_rem, dividend} left by 1 and trial-subtract the divisor.
    - If there is no borrow, keep the difference and set quotient bit = 1; else restore and set quotient bit = 0.
    - counter++.
    - After the WIDTH-th iteration (counter == WIDTH-1 at the edge), go to FIX.
  - FIX, one edge:
    - Apply the sign correction: negate the quotient if neg_q, negate the remainder if neg_r.
    - Write the quotient and remainder outputs, set data_ok = 1, go to DONE.
  - DONE, one edge:
    - data_ok = 0, go to IDLE.
    - valid is ignored on this edge, so an old request still held high cannot restart.
- Latency:
  - data_ok rises after the (WIDTH+2)-th edge counted from the accepting edge inclusive.
  - With WIDTH = 64, that is 66 cycles.
- Outputs hold their last value until the next FIX. data_ok is high for exactly one cycle per request.
- Abort: valid = 0 in BUSY or FIX returns to IDLE on the next edge with data_ok = 0; the outputs are unchanged.
- Special cases:
  - Divide by zero: quotient = all ones, remainder = srca (signed and unsigned alike).
  - Signed overflow (srca = most-negative, srcb = -1): quotient = srca, remainder = 0.
  - With the fast path compiled out, both cases fall out of the normal iteration plus the neg_q/neg_r rules above.
- Width rules:
  - The partial remainder is WIDTH+1 bits internally, so the borrow is explicit.
  - The most-negative magnitude is handled as unsigned 2^(WIDTH-1), with no overflow.
- Operand changes while BUSY have no effect.

Optional Feature:
- Macro: DIVIDER_FASTPATH_EN.
- Defined:
  - In IDLE, detect srcb == 0 or signed overflow on accept.
  - Go directly to FIX with the special-case results preloaded.
  - data_ok follows 2 edges after accept.
- Undefined:
  - All requests take the full WIDTH+2 cycles.
  - Results are bit-identical to the defined build.

Decomposition:
- Package pipes holds:
  - div_state_t enum {IDLE, BUSY, FIX, DONE}.
  - The WIDTH default constant, shared with the multiplier.
- Sub-module div_step: a combinational single-iteration restoring step.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once inside divider.

Test Plan:
- Unsigned divide: srca = 100, srcb = 7, is_signed = 0, valid held.
  - data_ok after 66 cycles, quotient = 14, remainder = 2, data_ok high 1 cycle.
- Signed divide: srca = -100, srcb = 7, is_signed = 1.
  - quotient = -14 (0xFFFF_FFFF_FFFF_FFF2), remainder = -2.
- Signed divide by negative divisor: srca = 100, srcb = -7.
  - quotient = -14, remainder = 2.
- Divide by zero: srca = 0x1234, srcb = 0, both is_signed values.
  - quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 0x1234.
  - Latency is 66 cycles, or 2 cycles with DIVIDER_FASTPATH_EN.
- Signed overflow: srca = 0x8000_0000_0000_0000, srcb = -1, is_signed = 1.
  - quotient = 0x8000_0000_0000_0000, remainder = 0.
- Abort and reset:
  - Drop valid at cycle 30: no data_ok, and the next request (9/3) returns quotient = 3, remainder = 0 with full latency.
  - Pulse resetn low at cycle 40 of a request: outputs and data_ok read 0 immediately (asynchronous).

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared execute-stage pipe definitions: datapath width default and the
// divider state encoding.
package pipes;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not borrow.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // The trial value is WIDTH+1 bits, so the borrow is an explicit compare.
    // When it does not borrow the true difference is below 2^WIDTH, so the
    // WIDTH-bit subtraction is exact.
    always_comb begin
        trial   = {rem_i, dvd_msb_i};
        q_bit_o = (trial >= {1'b0, dvs_i});
        diff    = trial[WIDTH-1:0] - dvs_i;
        rem_o   = q_bit_o ? diff : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU
// results. Optional macro DIVIDER_FASTPATH_EN short-cuts divide-by-zero and signed overflow.
module divider
    import pipes::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             data_ok
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pr_q, pr_d;    // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;  // dividend, becomes the quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;  // divisor magnitude
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             data_ok_q, data_ok_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
`ifdef DIVIDER_FASTPATH_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic             special;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (pr_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pr_d        = pr_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        data_ok_d   = 1'b0;

        // Negating the most-negative value yields itself, read as unsigned 2^(WIDTH-1).
        mag_a = (is_signed && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
        mag_b = (is_signed && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
`ifdef DIVIDER_FASTPATH_EN
        special = (srcb == '0) || (is_signed && (srca == MOST_NEG) && (srcb == '1));
`endif

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    dvd_d   = mag_a;
                    dvs_d   = mag_b;
                    pr_d    = '0;
                    cnt_d   = '0;
                    neg_q_d = is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]) & (srcb != '0);
                    neg_r_d = is_signed & srca[WIDTH-1];
                    state_d = BUSY;
`ifdef DIVIDER_FASTPATH_EN
                    // Preload what the full iteration would leave behind.
                    if (special) begin
                        dvd_d   = (srcb == '0) ? '1 : mag_a;
                        pr_d    = (srcb == '0) ? mag_a : '0;
                        state_d = FIX;
                    end
`endif
                end
            end
            BUSY: begin
                if (!valid) begin
                    state_d = IDLE;
                end else begin
                    pr_d  = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (!valid) begin
                    state_d = IDLE;
                end else begin
                    quotient_d  = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
                    remainder_d = neg_r_q ? (~pr_q + 1'b1) : pr_q;
                    data_ok_d   = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // A request still held high from the finished operation must not restart.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pr_q        <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            data_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pr_q        <= pr_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            data_ok_q   <= data_ok_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign data_ok   = data_ok_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results come from a behavioural
// RISC-V division model and are popped when data_ok pulses.
module tb_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic         valid;
    logic         is_signed;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         data_ok;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] last_q  = '0;
    logic [W-1:0] last_r  = '0;

    divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .is_signed (is_signed),
        .srca      (srca),
        .srcb      (srcb),
        .quotient  (quotient),
        .remainder (remainder),
        .data_ok   (data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t               e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sbv;
        sa  = a;
        sbv = b;
        e.lat = W + 2;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (s && a == MOST_NEG && b == '1) begin
            e.q = a;
            e.r = '0;
        end else if (s) begin
            e.q = sa / sbv;
            e.r = sa % sbv;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
`ifdef DIVIDER_FASTPATH_EN
        if (b == '0 || (s && a == MOST_NEG && b == '1)) e.lat = 2;
`endif
        return e;
    endfunction

    task automatic run_req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
        exp_t e;
        int   edges;
        logic seen;
        sb.push_back(model(a, b, s));
        @(negedge clk);
        srca      = a;
        srcb      = b;
        is_signed = s;
        valid     = 1'b1;
        edges     = 0;
        seen      = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            // Operands are only sampled at accept; scramble them afterwards.
            if (edges == 1) begin
                srca = {$urandom, $urandom};
                srcb = {$urandom, $urandom};
                is_signed = ~s;
            end
            seen = data_ok;
        end
        check({tag, "_data_ok"}, {{(W-1){1'b0}}, data_ok}, 1);
        e = sb.pop_front();
        if (seen) begin
            check({tag, "_quotient"}, quotient, e.q);
            check({tag, "_remainder"}, remainder, e.r);
            check({tag, "_latency"}, W'(edges), W'(e.lat));
            last_q = e.q;
            last_r = e.r;
            @(posedge clk);
            #1;
            check({tag, "_pulse_width"}, {{(W-1){1'b0}}, data_ok}, 0);
        end
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_no_restart"}, {{(W-1){1'b0}}, data_ok}, 0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (data_ok) saw = 1'b1;
        end
        check({tag, "_no_data_ok"}, {{(W-1){1'b0}}, saw}, 0);
        check({tag, "_quotient_held"}, quotient, last_q);
        check({tag, "_remainder_held"}, remainder, last_r);
    endtask

    initial begin
        resetn    = 1'b0;
        valid     = 1'b0;
        is_signed = 1'b0;
        srca      = '0;
        srcb      = '0;
        #1;
        check("reset_quotient", quotient, '0);
        check("reset_remainder", remainder, '0);
        check("reset_data_ok", {{(W-1){1'b0}}, data_ok}, 0);
        #20;
        @(negedge clk);
        resetn = 1'b1;

        run_req("udiv_100_7", 64'd100, 64'd7, 1'b0);
        run_req("sdiv_m100_7", -64'sd100, 64'd7, 1'b1);
        run_req("sdiv_100_m7", 64'd100, -64'sd7, 1'b1);
        run_req("sdiv_m100_m7", -64'sd100, -64'sd7, 1'b1);
        run_req("udiv_m100_7", -64'sd100, 64'd7, 1'b0);
        run_req("udiv_zero", 64'h1234, 64'd0, 1'b0);
        run_req("sdiv_zero", 64'h1234, 64'd0, 1'b1);
        run_req("sdiv_zero_neg", -64'sd5, 64'd0, 1'b1);
        run_req("sdiv_overflow", MOST_NEG, '1, 1'b1);
        run_req("sdiv_mostneg_1", MOST_NEG, 64'd1, 1'b1);
        run_req("udiv_mostneg_m1", MOST_NEG, '1, 1'b0);
        run_req("udiv_max_1", '1, 64'd1, 1'b0);
        run_req("udiv_small_big", 64'd3, 64'd10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = {$urandom, $urandom};
            b = (i < 3) ? W'($urandom) : {$urandom, $urandom};
            run_req($sformatf("rand_%0d", i), a, b, i[0]);
        end

        // Abort: drop valid at cycle 30 of a request.
        @(negedge clk);
        srca = 64'd50; srcb = 64'd5; is_signed = 1'b0; valid = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        watch_quiet("abort", 100);
        run_req("after_abort_9_3", 64'd9, 64'd3, 1'b0);

        // Asynchronous reset at cycle 40 of a request.
        @(negedge clk);
        srca = 64'd1000; srcb = 64'd3; is_signed = 1'b0; valid = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_reset_quotient", quotient, '0);
        check("mid_reset_remainder", remainder, '0);
        check("mid_reset_data_ok", {{(W-1){1'b0}}, data_ok}, 0);
        valid = 1'b0;
        #3;
        resetn = 1'b1;
        last_q = '0;
        last_r = '0;
        watch_quiet("post_reset", 100);
        run_req("after_reset_1000_3", 64'd1000, 64'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
